// File: rtl/raizing_gfx_pkg.sv
// Shared types and constants for the Raizing graphics ROM server.
//   ch_t     : 2-bit channel index (OBJ, SCR0, SCR1, SCR2)
//   state_t  : SDRAM read sequencer states
//   DEF_AW/DEF_DW : default word address / data widths
package raizing_gfx_pkg;

  localparam int DEF_AW = 22;
  localparam int DEF_DW = 32;
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_t;

  localparam ch_t CH_OBJ  = 2'd0;
  localparam ch_t CH_SCR0 = 2'd1;
  localparam ch_t CH_SCR1 = 2'd2;
  localparam ch_t CH_SCR2 = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/raizing_gfx_cache_slot.sv
// One-word read cache for a single graphics ROM channel.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_cs, i_addr      : channel request and word address
//   i_fill_we         : write tag/data and set valid (one cycle)
//   i_fill_addr/data  : address and data written on a fill
//   o_hit             : combinational hit for the presented address
//   o_ok, o_dout      : registered data-valid and data back to the channel
module raizing_gfx_cache_slot
  import raizing_gfx_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill_we,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_hit,
  output logic          o_ok,
  output logic [DW-1:0] o_dout
);

  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ok;
  logic [DW-1:0] r_dout;

  assign o_hit = i_cs & r_valid & (i_addr == r_tag);

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_dout  <= '0;
    end else begin
      if (i_fill_we) r_valid <= 1'b1;
      r_ok <= o_hit;
      // DOUT only follows the cache on a hit, so it keeps its last value while OK is low.
      if (o_hit) r_dout <= r_data;
    end
  end

  // NOTE: tag/data storage is not reset; r_valid alone decides whether its contents mean anything.
  always_ff @(posedge i_clk) begin
    if (i_fill_we) begin
      r_tag  <= i_fill_addr;
      r_data <= i_fill_data;
    end
  end

  assign o_ok   = r_ok;
  assign o_dout = r_dout;

endmodule

// File: rtl/raizing_gfx_rom_server.sv
// Graphics ROM responder: four one-word channel caches (OBJ, SCR0, SCR1,
// SCR2) whose misses are arbitrated onto one SDRAM read port.
//   CLK, RESET                  : clock, asynchronous active-high reset
//   GFX*_CS / GFX*_ADDR         : per-channel request and word address
//   GFX*_OK / GFX*_DOUT         : per-channel registered data-valid and data
//   SDRAM_REQ / SDRAM_ADDR      : read request (held until ACK) and address
//   SDRAM_ACK / SDRAM_DST       : request accepted / read data valid pulses
//   SDRAM_DATA                  : read data
module raizing_gfx_rom_server
  import raizing_gfx_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int RR = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          GFX_CS,
  input  logic [AW-1:0] GFX_ADDR,
  output logic          GFX_OK,
  output logic [DW-1:0] GFX_DOUT,
  input  logic          GFXSCR0_CS,
  input  logic [AW-1:0] GFXSCR0_ADDR,
  output logic          GFXSCR0_OK,
  output logic [DW-1:0] GFXSCR0_DOUT,
  input  logic          GFXSCR1_CS,
  input  logic [AW-1:0] GFXSCR1_ADDR,
  output logic          GFXSCR1_OK,
  output logic [DW-1:0] GFXSCR1_DOUT,
  input  logic          GFXSCR2_CS,
  input  logic [AW-1:0] GFXSCR2_ADDR,
  output logic          GFXSCR2_OK,
  output logic [DW-1:0] GFXSCR2_DOUT,
  output logic          SDRAM_REQ,
  output logic [AW-1:0] SDRAM_ADDR,
  input  logic          SDRAM_ACK,
  input  logic          SDRAM_DST,
  input  logic [DW-1:0] SDRAM_DATA
);

  logic [NUM_CH-1:0] w_cs;
  logic [AW-1:0]     w_addr [NUM_CH];
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_ok;
  logic [DW-1:0]     w_dout [NUM_CH];
  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_fill_we;

  state_t        r_state, w_state_nxt;
  ch_t           r_sel, w_sel_nxt;
  ch_t           r_ptr, w_ptr_nxt;
  logic          r_req, w_req_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          w_fill;
  logic          w_found;
  ch_t           w_win;
  ch_t           w_base;
  ch_t           w_idx;

  assign w_cs      = {GFXSCR2_CS, GFXSCR1_CS, GFXSCR0_CS, GFX_CS};
  assign w_addr[0] = GFX_ADDR;
  assign w_addr[1] = GFXSCR0_ADDR;
  assign w_addr[2] = GFXSCR1_ADDR;
  assign w_addr[3] = GFXSCR2_ADDR;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    raizing_gfx_cache_slot #(.AW(AW), .DW(DW)) u_slot (
      .i_clk       (CLK),
      .i_rst       (RESET),
      .i_cs        (w_cs[gi]),
      .i_addr      (w_addr[gi]),
      .i_fill_we   (w_fill_we[gi]),
      .i_fill_addr (r_addr),
      .i_fill_data (SDRAM_DATA),
      .o_hit       (w_hit[gi]),
      .o_ok        (w_ok[gi]),
      .o_dout      (w_dout[gi])
    );
  end

  // Pending excludes a channel whose current address is already being fetched,
  // so it does not queue a duplicate request while the fill is outstanding.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_pend[i] = w_cs[i] & ~w_hit[i] &
                  ~((r_state != IDLE) & (r_sel == ch_t'(i)) & (w_addr[i] == r_addr));
    end
  end

  // Scan starts at the round-robin pointer (or OBJ for fixed priority); the
  // 2-bit index wraps naturally from SCR2 back to OBJ.
  always_comb begin
    w_base  = (RR != 0) ? r_ptr : CH_OBJ;
    w_win   = CH_OBJ;
    w_found = 1'b0;
    w_idx   = CH_OBJ;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = w_base + ch_t'(k);
      if (!w_found && w_pend[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_fill      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_win;
          w_addr_nxt  = w_addr[w_win];
          w_req_nxt   = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (SDRAM_ACK) begin
          w_req_nxt = 1'b0;
          // DST coinciding with ACK is taken as ACK followed by DST.
          if (SDRAM_DST) begin
            w_fill      = 1'b1;
            w_ptr_nxt   = r_sel + 2'd1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (SDRAM_DST) begin
          w_fill      = 1'b1;
          w_ptr_nxt   = r_sel + 2'd1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_fill_we = w_fill ? (NUM_CH'(1) << r_sel) : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_sel   <= CH_OBJ;
      r_ptr   <= CH_OBJ;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign SDRAM_REQ    = r_req;
  assign SDRAM_ADDR   = r_addr;
  assign GFX_OK       = w_ok[0];
  assign GFX_DOUT     = w_dout[0];
  assign GFXSCR0_OK   = w_ok[1];
  assign GFXSCR0_DOUT = w_dout[1];
  assign GFXSCR1_OK   = w_ok[2];
  assign GFXSCR1_DOUT = w_dout[2];
  assign GFXSCR2_OK   = w_ok[3];
  assign GFXSCR2_DOUT = w_dout[3];

endmodule

// File: tb/tb_raizing_gfx_rom_server.sv
// Scoreboard bench for raizing_gfx_rom_server: stimulus pushes expected
// SDRAM request addresses and per-channel OK data; a monitor pops and
// compares whenever the DUT raises SDRAM_REQ or a channel OK.
module tb_raizing_gfx_rom_server;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          cs   [4];
  logic [AW-1:0] addr [4];
  logic          GFX_OK, GFXSCR0_OK, GFXSCR1_OK, GFXSCR2_OK;
  logic [DW-1:0] GFX_DOUT, GFXSCR0_DOUT, GFXSCR1_DOUT, GFXSCR2_DOUT;
  logic          SDRAM_REQ;
  logic [AW-1:0] SDRAM_ADDR;
  logic          SDRAM_ACK, SDRAM_DST;
  logic [DW-1:0] SDRAM_DATA;

  always #5 CLK = ~CLK;

  raizing_gfx_rom_server #(.AW(AW), .DW(DW), .RR(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .GFX_CS(cs[0]), .GFX_ADDR(addr[0]), .GFX_OK(GFX_OK), .GFX_DOUT(GFX_DOUT),
    .GFXSCR0_CS(cs[1]), .GFXSCR0_ADDR(addr[1]), .GFXSCR0_OK(GFXSCR0_OK), .GFXSCR0_DOUT(GFXSCR0_DOUT),
    .GFXSCR1_CS(cs[2]), .GFXSCR1_ADDR(addr[2]), .GFXSCR1_OK(GFXSCR1_OK), .GFXSCR1_DOUT(GFXSCR1_DOUT),
    .GFXSCR2_CS(cs[3]), .GFXSCR2_ADDR(addr[3]), .GFXSCR2_OK(GFXSCR2_OK), .GFXSCR2_DOUT(GFXSCR2_DOUT),
    .SDRAM_REQ(SDRAM_REQ), .SDRAM_ADDR(SDRAM_ADDR), .SDRAM_ACK(SDRAM_ACK),
    .SDRAM_DST(SDRAM_DST), .SDRAM_DATA(SDRAM_DATA)
  );

  logic [3:0]    ok_v;
  logic [DW-1:0] dout_v [4];
  assign ok_v      = {GFXSCR2_OK, GFXSCR1_OK, GFXSCR0_OK, GFX_OK};
  assign dout_v[0] = GFX_DOUT;
  assign dout_v[1] = GFXSCR0_DOUT;
  assign dout_v[2] = GFXSCR1_DOUT;
  assign dout_v[3] = GFXSCR2_DOUT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dst_cyc = 0;
  int req_cnt = 0;
  int ack_lat = 0;
  int dst_lat = 3;
  bit resp_en = 1'b1;

  // Queues 0..3: expected DOUT at each channel OK rise; queue 4: expected SDRAM_ADDR at each REQ rise.
  logic [31:0] exp_q [5][$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got event with value 0x%08h expected no event", name, act);
  endtask

  // SDRAM contents for the addresses the bench touches.
  function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
    case (a)
      22'h001234: mem_data = 32'hDEADBEEF;
      22'h000010: mem_data = 32'h1010A0A0;
      22'h000020: mem_data = 32'h2020B0B0;
      22'h000030: mem_data = 32'h3030C0C0;
      22'h000040: mem_data = 32'h4040D0D0;
      22'h000050: mem_data = 32'h5050E0E0;
      22'h000044: mem_data = 32'h44440044;
      22'h000054: mem_data = 32'h54540054;
      22'h000100: mem_data = 32'h01000100;
      22'h000104: mem_data = 32'h01040104;
      22'h000200: mem_data = 32'h02002222;
      22'h000300: mem_data = 32'h03003333;
      default:    mem_data = 32'hBAD00000;
    endcase
  endfunction

  // SDRAM responder: ACK ack_lat cycles after REQ is seen, DST dst_lat cycles after ACK.
  initial begin : responder
    logic [AW-1:0] a;
    SDRAM_ACK  = 1'b0;
    SDRAM_DST  = 1'b0;
    SDRAM_DATA = '0;
    forever begin
      @(negedge CLK);
      if (resp_en && SDRAM_REQ && !RESET) begin
        repeat (ack_lat) @(negedge CLK);
        a = SDRAM_ADDR;
        SDRAM_ACK = 1'b1;
        if (dst_lat == 0) begin
          SDRAM_DATA = mem_data(a);
          SDRAM_DST  = 1'b1;
          dst_cyc    = cyc;
        end
        @(negedge CLK);
        SDRAM_ACK = 1'b0;
        SDRAM_DST = 1'b0;
        if (dst_lat > 0) begin
          repeat (dst_lat - 1) @(negedge CLK);
          SDRAM_DATA = mem_data(a);
          SDRAM_DST  = 1'b1;
          dst_cyc    = cyc;
          @(negedge CLK);
          SDRAM_DST = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [3:0] prev_ok;
    logic       prev_req;
    prev_ok  = 4'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge CLK);
      for (int s = 0; s < 4; s++) begin
        if (ok_v[s] && !prev_ok[s]) begin
          if (exp_q[s].size() == 0) flag_unexpected($sformatf("unexpected_ok_ch%0d", s), dout_v[s]);
          else check($sformatf("ok_data_ch%0d", s), dout_v[s], exp_q[s].pop_front());
        end
      end
      if (SDRAM_REQ && !prev_req) begin
        req_cnt++;
        if (exp_q[4].size() == 0) flag_unexpected("unexpected_req", 32'(SDRAM_ADDR));
        else check("req_addr", 32'(SDRAM_ADDR), exp_q[4].pop_front());
      end
      prev_ok  = ok_v;
      prev_req = SDRAM_REQ;
    end
  end

  function automatic int pending_total();
    int n = 0;
    for (int s = 0; s < 5; s++) n += exp_q[s].size();
    return n;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (pending_total() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (pending_total() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout with %0d events outstanding, expected 0", name, pending_total());
      for (int s = 0; s < 5; s++) exp_q[s].delete();
    end
  endtask

  task automatic wait_req(input logic [AW-1:0] a, input int budget, input string name);
    int n = 0;
    while (!(SDRAM_REQ && SDRAM_ADDR == a) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!(SDRAM_REQ && SDRAM_ADDR == a)) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, SDRAM_ADDR 0x%06h expected request for 0x%06h", name, SDRAM_ADDR, a);
    end
  endtask

  task automatic wait_ok(input int ch, input int budget, input string name);
    int n = 0;
    while (!ok_v[ch] && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (!ok_v[ch]) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, OK 0 expected 1", name);
    end
  endtask

  task automatic do_reset();
    for (int s = 0; s < 4; s++) cs[s] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n0;
    int viol;
    for (int s = 0; s < 4; s++) begin
      cs[s]   = 1'b0;
      addr[s] = '0;
    end

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ok", 32'(ok_v), 32'h0);
    for (int s = 0; s < 4; s++) check($sformatf("rst_dout_ch%0d", s), dout_v[s], 32'h0);
    check("rst_req", 32'(SDRAM_REQ), 32'h0);
    check("rst_addr", 32'(SDRAM_ADDR), 32'h0);
    RESET = 1'b0;
    @(negedge CLK);

    // Cold miss on OBJ
    exp_q[4].push_back(32'h001234);
    exp_q[0].push_back(32'hDEADBEEF);
    n0 = req_cnt;
    cs[0]   = 1'b1;
    addr[0] = 22'h001234;
    wait_ok(0, 40, "cold_ok_timeout");
    check("cold_ok_latency", 32'(cyc - dst_cyc), 32'd2);
    check("cold_dout", GFX_DOUT, 32'hDEADBEEF);
    repeat (4) @(negedge CLK);
    check("cold_req_count", 32'(req_cnt - n0), 32'd1);

    // Hit after CS low for 5 cycles
    cs[0] = 1'b0;
    @(negedge CLK);
    check("ok_fall_after_cs", 32'(GFX_OK), 32'h0);
    repeat (4) @(negedge CLK);
    exp_q[0].push_back(32'hDEADBEEF);
    n0 = req_cnt;
    cs[0] = 1'b1;
    @(negedge CLK);
    check("hit_ok_next_cycle", 32'(GFX_OK), 32'h1);
    repeat (3) @(negedge CLK);
    check("hit_no_req", 32'(req_cnt - n0), 32'd0);

    // Round-robin from a fresh pointer: four simultaneous misses
    do_reset();
    exp_q[4].push_back(32'h10);
    exp_q[4].push_back(32'h20);
    exp_q[4].push_back(32'h30);
    exp_q[4].push_back(32'h40);
    exp_q[0].push_back(32'h1010A0A0);
    exp_q[1].push_back(32'h2020B0B0);
    exp_q[2].push_back(32'h3030C0C0);
    exp_q[3].push_back(32'h4040D0D0);
    addr[0] = 22'h10; addr[1] = 22'h20; addr[2] = 22'h30; addr[3] = 22'h40;
    for (int s = 0; s < 4; s++) cs[s] = 1'b1;
    wait_drain(200, "rr_drain");
    @(negedge CLK);
    check("rr_all_ok", 32'(ok_v), 32'hF);
    check("rr_dout_scr2", GFXSCR2_DOUT, 32'h4040D0D0);

    // OBJ re-misses continuously; SCR2 must still be served before OBJ's second miss
    exp_q[4].push_back(32'h50);
    exp_q[4].push_back(32'h44);
    exp_q[4].push_back(32'h54);
    exp_q[3].push_back(32'h44440044);
    exp_q[0].push_back(32'h54540054);
    addr[0] = 22'h50;
    addr[3] = 22'h44;
    wait_req(22'h50, 20, "starve_req50");
    addr[0] = 22'h54;
    wait_drain(200, "starve_drain");
    @(negedge CLK);
    check("starve_obj_dout", GFX_DOUT, 32'h54540054);
    check("starve_scr2_dout", GFXSCR2_DOUT, 32'h44440044);

    // SCR1 address change while its fill is in flight
    exp_q[4].push_back(32'h100);
    exp_q[4].push_back(32'h104);
    exp_q[2].push_back(32'h01040104);
    addr[2] = 22'h100;
    wait_req(22'h100, 20, "midflight_req100");
    addr[2] = 22'h104;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (GFXSCR1_OK) viol++;
    end
    check("midflight_no_stale_ok", 32'(viol), 32'd0);
    wait_drain(200, "midflight_drain");
    @(negedge CLK);
    check("midflight_ok", 32'(GFXSCR1_OK), 32'h1);
    check("midflight_dout", GFXSCR1_DOUT, 32'h01040104);

    // ACK held off for 20 cycles
    ack_lat = 20;
    exp_q[4].push_back(32'h200);
    exp_q[1].push_back(32'h02002222);
    addr[1] = 22'h200;
    wait_req(22'h200, 20, "bp_req");
    viol = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      if (!(SDRAM_REQ && SDRAM_ADDR == 22'h200)) viol++;
    end
    check("bp_req_stable", 32'(viol), 32'd0);
    wait_drain(200, "bp_drain");
    ack_lat = 0;
    @(negedge CLK);
    check("bp_dout", GFXSCR0_DOUT, 32'h02002222);

    // Async reset while waiting for data, then a stray DST
    resp_en = 1'b0;
    exp_q[4].push_back(32'h300);
    addr[3] = 22'h300;
    wait_req(22'h300, 20, "rst_req300");
    SDRAM_ACK = 1'b1;
    @(negedge CLK);
    SDRAM_ACK = 1'b0;
    #1 RESET = 1'b1;
    #1;
    check("async_rst_ok", 32'(ok_v), 32'h0);
    check("async_rst_req", 32'(SDRAM_REQ), 32'h0);
    check("async_rst_addr", 32'(SDRAM_ADDR), 32'h0);
    for (int s = 0; s < 4; s++) check($sformatf("async_rst_dout_ch%0d", s), dout_v[s], 32'h0);
    for (int s = 0; s < 4; s++) cs[s] = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    SDRAM_DATA = 32'h55AA55AA;
    SDRAM_DST  = 1'b1;
    @(negedge CLK);
    SDRAM_DST = 1'b0;
    exp_q[4].push_back(32'h300);
    cs[3] = 1'b1;
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (GFXSCR2_OK) viol++;
    end
    check("stray_dst_no_ok", 32'(viol), 32'd0);
    exp_q[3].push_back(32'h03003333);
    resp_en = 1'b1;
    wait_drain(200, "post_rst_drain");
    @(negedge CLK);
    check("post_rst_dout", GFXSCR2_DOUT, 32'h03003333);

    repeat (5) @(negedge CLK);
    check("sb_empty", 32'(pending_total()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
